l2_cache_controller: RTL and testbench

Sequencing controller for the 4-way, 16-set, 512-bit-line L2 data array. It owns the L2 tag/valid/dirty/pseudo-LRU state, serves one L1 request at a time, and drives the data array's `index_L1_L2`, `way`, `update` and `refill` controls. On a miss it performs a dirty-victim writeback and a line refill through a req/ack memory handshake.

---
 rtl/l2_cache_controller.sv | 164 ++++++++++++++++
 tb/tb_l2_cache_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_controller.sv
// Sequencing controller for a 4-way, 16-set L2: owns tag/valid/dirty/PLRU state,
// serves one L1 request at a time and runs writeback/refill over a req/ack memory port.
module l2_cache_controller #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = ADDR_W - 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_L1_L2,
  input  logic              we_L1_L2,
  input  logic [ADDR_W-1:0] addr_L1_L2,
  output logic              ready_L2_L1,
  output logic [3:0]        index_L1_L2,
  output logic [1:0]        way,
  output logic              update,
  output logic              refill,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WB, S_REFILL} state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-7:0] r_line;
  logic              r_we;
  logic [1:0]        r_victim;
  logic [TAG_W-1:0]  r_tag   [16][4];
  logic [3:0]        r_valid [16];
  logic [3:0]        r_dirty [16];
  logic [15:0]       r_b0;
  logic [15:0]       r_b1;
  logic [15:0]       r_b2;

  logic [3:0]       w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [1:0]       w_hit_way;
  logic [1:0]       w_vict;
  logic             w_unused_offset;

  // Byte offset never matters: the array moves whole lines.
  assign w_unused_offset = ^addr_L1_L2[5:0];

  assign w_idx = r_line[3:0];
  assign w_tag = r_line[ADDR_W-7:4];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 2'(i);
      end
    end
  end

  // Invalid ways are preferred (lowest first); otherwise follow the PLRU tree.
  always_comb begin
    if (!r_b0[w_idx]) w_vict = r_b1[w_idx] ? 2'd1 : 2'd0;
    else              w_vict = r_b2[w_idx] ? 2'd3 : 2'd2;
    for (int i = 3; i >= 0; i--) begin
      if (!r_valid[w_idx][i]) w_vict = 2'(i);
    end
  end

  always_comb begin
    w_next      = r_state;
    ready_L2_L1 = 1'b0;
    update      = 1'b0;
    refill      = 1'b0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    index_L1_L2 = 4'd0;
    way         = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (req_L1_L2) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        index_L1_L2 = w_idx;
        way         = w_hit_way;
        if (w_hit) begin
          ready_L2_L1 = 1'b1;
          update      = r_we;
          w_next      = S_IDLE;
        end else if (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) begin
          w_next = S_WB;
        end else begin
          w_next = S_REFILL;
        end
      end
      S_WB: begin
        index_L1_L2 = w_idx;
        way         = r_victim;
        mem_wr_req  = 1'b1;
        mem_addr    = {r_tag[w_idx][r_victim], w_idx, 6'b0};
        if (mem_ack) w_next = S_REFILL;
      end
      S_REFILL: begin
        index_L1_L2 = w_idx;
        way         = r_victim;
        mem_rd_req  = 1'b1;
        mem_addr    = {w_tag, w_idx, 6'b0};
        if (mem_ack) begin
          refill = 1'b1;
          w_next = S_COMPARE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b0    <= '0;
      r_b1    <= '0;
      r_b2    <= '0;
      for (int s = 0; s < 16; s++) begin
        r_valid[s] <= 4'd0;
        r_dirty[s] <= 4'd0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_COMPARE: begin
          if (w_hit) begin
            r_b0[w_idx] <= ~w_hit_way[1];
            if (!w_hit_way[1]) r_b1[w_idx] <= ~w_hit_way[0];
            else               r_b2[w_idx] <= ~w_hit_way[0];
            if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_ack) r_dirty[w_idx][r_victim] <= 1'b0;
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch, victim and tag storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_L1_L2) begin
      r_line <= addr_L1_L2[ADDR_W-1:6];
      r_we   <= we_L1_L2;
    end
    if (r_state == S_COMPARE && !w_hit) r_victim <= w_vict;
    if (r_state == S_REFILL && mem_ack) r_tag[w_idx][r_victim] <= w_tag;
  end

endmodule

// File: tb/tb_l2_cache_controller.sv
// Scoreboard bench for l2_cache_controller: a set/way reference model predicts
// memory transactions and completions, a monitor checks what the DUT presents.
module tb_l2_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_L1_L2;
  logic        we_L1_L2;
  logic [31:0] addr_L1_L2;
  logic        ready_L2_L1;
  logic [3:0]  index_L1_L2;
  logic [1:0]  way;
  logic        update;
  logic        refill;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic        mem_ack;

  l2_cache_controller #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_L1_L2(req_L1_L2), .we_L1_L2(we_L1_L2),
    .addr_L1_L2(addr_L1_L2), .ready_L2_L1(ready_L2_L1), .index_L1_L2(index_L1_L2),
    .way(way), .update(update), .refill(refill), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  localparam int K_WB  = 0;
  localparam int K_RD  = 1;
  localparam int K_RDY = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  way;
    logic        upd;
    logic [3:0]  idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   ack_en = 1'b1;
  bit   force_ack = 1'b0;

  // Reference model: plain per-set arrays and the PLRU tree as three named bits.
  logic [21:0] m_tag   [16][4];
  bit          m_valid [16][4];
  bit          m_dirty [16][4];
  bit          m_b0 [16];
  bit          m_b1 [16];
  bit          m_b2 [16];

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
      end
    end
  endfunction

  function automatic void push(int k, logic [31:0] a, int w, bit u, int ix);
    exp_t e;
    e.kind = k; e.addr = a; e.way = 2'(w); e.upd = u; e.idx = 4'(ix);
    q.push_back(e);
  endfunction

  function automatic bit model_req(logic [31:0] a, bit wr);
    int ix = int'(a[9:6]);
    logic [21:0] t = a[31:10];
    int w = -1;
    bit was_hit;
    for (int i = 0; i < 4; i++)
      if (m_valid[ix][i] && m_tag[ix][i] == t) w = i;
    was_hit = (w >= 0);
    if (!was_hit) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[ix][i]) w = i;
      if (w < 0) w = (m_b0[ix] == 0) ? (m_b1[ix] ? 1 : 0) : (m_b2[ix] ? 3 : 2);
      if (m_valid[ix][w] && m_dirty[ix][w])
        push(K_WB, {m_tag[ix][w], 4'(ix), 6'b0}, w, 0, ix);
      push(K_RD, {t, 4'(ix), 6'b0}, w, 0, ix);
      m_tag[ix][w] = t; m_valid[ix][w] = 1; m_dirty[ix][w] = 0;
    end
    push(K_RDY, 32'd0, w, wr, ix);
    m_b0[ix] = (w < 2);
    if (w < 2) m_b1[ix] = (w == 0);
    else       m_b2[ix] = (w == 2);
    if (wr) m_dirty[ix][w] = 1;
    return was_hit;
  endfunction

  task automatic finish_sim();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: actual %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Memory responder: random latency, and random stray acks while nothing is requested.
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_en && (mem_rd_req || mem_wr_req)) begin
        if (cnt == 0) cnt = $urandom_range(1, 4);
        cnt--;
        mem_ack = (cnt == 0);
      end else begin
        mem_ack = force_ack | (ack_en & ($urandom_range(0, 3) == 0));
      end
    end
  end

  task automatic check_event(int k, logic [31:0] a, bit upd_now, bit ref_now);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d addr %h way %0d, required nothing", k, a, way);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.way != way || e.idx != index_L1_L2 ||
        (k != K_RDY && e.addr != a) || upd_now != (k == K_RDY && e.upd) ||
        ref_now != (k == K_RD)) begin
      errors++;
      $display("FAIL event_kind%0d: actual kind %0d addr %h way %0d idx %0d upd %0d refill %0d, required kind %0d addr %h way %0d idx %0d upd %0d refill %0d",
               e.kind, k, a, way, index_L1_L2, upd_now, ref_now,
               e.kind, e.addr, e.way, e.idx, (e.kind == K_RDY) && e.upd, e.kind == K_RD);
    end
  endtask

  // Monitor: samples on the falling edge, independent of the stimulus driver.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if ((mem_rd_req && mem_wr_req) || (update && refill)) begin
          errors++;
          $display("FAIL exclusive_strobes: actual rd %0d wr %0d upd %0d ref %0d, required no overlap",
                   mem_rd_req, mem_wr_req, update, refill);
        end
        if (mem_wr_req && mem_ack) check_event(K_WB, mem_addr, update, refill);
        if (mem_rd_req && mem_ack) check_event(K_RD, mem_addr, update, refill);
        if (ready_L2_L1)           check_event(K_RDY, 32'd0, update, refill);
      end
    end
  end

  task automatic check_idle_outputs(string name);
    checks++;
    if ({ready_L2_L1, index_L1_L2, way, update, refill, mem_rd_req, mem_wr_req} != '0 ||
        mem_addr != 32'd0) begin
      errors++;
      $display("FAIL %s: actual rdy %0d idx %0d way %0d upd %0d ref %0d rd %0d wr %0d maddr %h, required all 0",
               name, ready_L2_L1, index_L1_L2, way, update, refill, mem_rd_req, mem_wr_req, mem_addr);
    end
  endtask

  task automatic do_req(logic [31:0] a, bit wr);
    bit hit;
    int n = 0;
    hit = model_req(a, wr);
    @(posedge clk); #1;
    req_L1_L2 = 1'b1; addr_L1_L2 = a; we_L1_L2 = wr;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_L2_L1 && n < 400);
    if (!ready_L2_L1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: actual no ready after %0d cycles for addr %h, required ready", n, a);
      finish_sim();
    end
    if (hit) begin
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL hit_latency: actual %0d cycles for addr %h, required 2", n, a);
      end
    end
    @(posedge clk); #1;
    req_L1_L2 = 1'b0; we_L1_L2 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_L1_L2 = 1'b0; we_L1_L2 = 1'b0; addr_L1_L2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(32'h0000_0040, 0);
    do_req(32'h0000_0040, 0);
    do_req(32'h0000_0040, 1);
    do_req(32'h0000_0440, 0);
    do_req(32'h0000_0840, 0);
    do_req(32'h0000_0C40, 0);
    do_req(32'h0000_0040, 0);
    do_req(32'h0000_1040, 0);
    do_req(32'h0000_0440, 0);
    do_req(32'h0000_1040, 0);
    do_req(32'h0000_1440, 0);
    do_req(32'h0000_1440, 1);
    do_req(32'h0000_0440, 0);
    do_req(32'h0000_0C40, 0);

    // Dirty victim 0x1440 in way 0: hold acks, then reset while WB is pending.
    void'(model_req(32'h0000_1840, 0));
    ack_en = 1'b0;
    @(posedge clk); #1;
    req_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_1840; we_L1_L2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_wr_req && n < 20);
    checks++;
    if (!mem_wr_req || mem_addr != 32'h0000_1440) begin
      errors++;
      $display("FAIL wb_before_reset: actual wr %0d maddr %h, required wr 1 maddr 00001440",
               mem_wr_req, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; force_ack = 1'b1; req_L1_L2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b0;
    check_idle_outputs("reset_mid_wb");
    checks++;
    if (q.size() != 3) begin
      errors++;
      $display("FAIL aborted_txn_pending: actual %0d, required 3", q.size());
    end
    q.delete();
    model_reset();
    ack_en = 1'b1;
    do_req(32'h0000_0040, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = {22'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 6'($urandom)};
      do_req(a, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    finish_sim();
  end

endmodule
